// File: rtl/sprite_pkg.sv
// Shared types and default configuration for the player-sprite address generator.
// Contents:
//   pose_t          sprite pose encoding (IDLE, RUN, DOWN, JUMP)
//   DEF_*           default sheet geometry and per-pose base addresses
//   idx_width()     width of a counter that holds 0..n-1 (never less than 1 bit)
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DOWN = 2'd2,
    JUMP = 2'd3
  } pose_t;

  localparam int DEF_SHEET_AW    = 21;
  localparam int DEF_SPR_W       = 68;
  localparam int DEF_SPR_H       = 34;
  localparam int DEF_NUM_FRAMES  = 4;
  localparam int DEF_FRAME_DIV   = 6;
  localparam int DEF_BASE_IDLE   = 0;
  localparam int DEF_BASE_RUN    = 2312;
  localparam int DEF_BASE_DOWN   = 21680;
  localparam int DEF_BASE_JUMP   = 23992;
  localparam int DEF_LEFT_OFFSET = 50620;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_frame_seq.sv
// Pose state machine, frame-tick divider and animation frame counter.
// pose_in and facing_in are sampled only on frame_tick, so everything this
// block drives is stable for a whole scanned video frame.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   frame_tick     one-cycle pulse per video frame
//   pose_in        requested pose
//   facing_in      requested facing (1 = left)
//   pose_o         current pose
//   facing_o       current facing
//   frame_o        current animation frame
module sprite_frame_seq
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int FRAME_DIV  = DEF_FRAME_DIV,
  parameter int FW         = idx_width(NUM_FRAMES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  pose_t         pose_in,
  input  logic          facing_in,
  output pose_t         pose_o,
  output logic          facing_o,
  output logic [FW-1:0] frame_o
);

  localparam int            DW        = idx_width(FRAME_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(FRAME_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);

  pose_t          state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic           facing_q, facing_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      frame_q  <= '0;
      facing_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
      facing_q <= facing_d;
    end
  end

  // NOTE: every signal gets a hold default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    frame_d  = frame_q;
    facing_d = facing_q;
    if (frame_tick) begin
      facing_d = facing_in;
      if (pose_in != state_q) begin
        // A new pose always starts its animation from the first frame.
        state_d = pose_in;
        div_d   = '0;
        frame_d = '0;
      end else if (div_q == DIV_LAST) begin
        div_d = '0;
        unique case (state_q)
          RUN:     frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FW'(1);
          JUMP:    frame_d = (frame_q == FRAME_LAST) ? frame_q : frame_q + FW'(1);
          default: frame_d = '0;
        endcase
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  assign pose_o   = state_q;
  assign facing_o = facing_q;
  assign frame_o  = frame_q;

endmodule

// File: rtl/sprite_anim_engine.sv
// Player-sprite address generator: one instance serves every pose.
// Per scanned pixel it performs the sprite hit test and computes the
// sprite-sheet ROM address through a 2-stage pipeline (2 Clk latency).
// Build option: define SPRITE_MIRROR_EN to mirror right-facing art
// horizontally for facing_left instead of adding LEFT_OFFSET.
// Ports:
//   Clk, Reset_n         clock, asynchronous active-low reset
//   frame_tick           one-Clk pulse per video frame
//   pose                 0=IDLE 1=RUN 2=DOWN 3=JUMP
//   facing_left          1 = player faces left
//   DrawX, DrawY         current scan pixel
//   PlayerX, PlayerY     sprite top-left corner
//   playerOn             pixel lies inside the sprite
//   spriteAddress        sprite-sheet ROM address (0 on a miss)
//   frameIdx             current animation frame
//   PlayerWidth/Height   constant sprite dimensions
module sprite_anim_engine
  import sprite_pkg::*;
#(
  parameter int SHEET_AW    = DEF_SHEET_AW,
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H,
  parameter int NUM_FRAMES  = DEF_NUM_FRAMES,
  parameter int FRAME_DIV   = DEF_FRAME_DIV,
  parameter int BASE_IDLE   = DEF_BASE_IDLE,
  parameter int BASE_RUN    = DEF_BASE_RUN,
  parameter int BASE_DOWN   = DEF_BASE_DOWN,
  parameter int BASE_JUMP   = DEF_BASE_JUMP,
  parameter int LEFT_OFFSET = DEF_LEFT_OFFSET,
  localparam int FW         = idx_width(NUM_FRAMES)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_tick,
  input  logic [1:0]          pose,
  input  logic                facing_left,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic [9:0]          PlayerX,
  input  logic [9:0]          PlayerY,
  output logic                playerOn,
  output logic [SHEET_AW-1:0] spriteAddress,
  output logic [FW-1:0]       frameIdx,
  output logic [9:0]          PlayerWidth,
  output logic [9:0]          PlayerHeight
);

  pose_t         pose_cur;
  logic          facing_cur;
  logic [FW-1:0] frame_cur;

  sprite_frame_seq #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV),
    .FW         (FW)
  ) u_frame_seq (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_tick (frame_tick),
    .pose_in    (pose_t'(pose)),
    .facing_in  (facing_left),
    .pose_o     (pose_cur),
    .facing_o   (facing_cur),
    .frame_o    (frame_cur)
  );

  // Stage 1: hit test and sprite-relative offsets. The compare runs at
  // 11 bits so a sprite near the right/bottom edge cannot wrap onto column 0.
  logic [10:0] draw_x11, draw_y11, play_x11, play_y11;
  logic        hit_d, hit_q;
  logic [9:0]  dx_d, dx_q, dy_d, dy_q;

  always_comb begin
    draw_x11 = {1'b0, DrawX};
    draw_y11 = {1'b0, DrawY};
    play_x11 = {1'b0, PlayerX};
    play_y11 = {1'b0, PlayerY};
    hit_d    = (draw_x11 >= play_x11) && (draw_x11 < play_x11 + 11'(SPR_W)) &&
               (draw_y11 >= play_y11) && (draw_y11 < play_y11 + 11'(SPR_H));
    dx_d     = DrawX - PlayerX;
    dy_d     = DrawY - PlayerY;
  end

  // Stage 2: address assembly. Pose, frame and facing are read from the
  // sequencer registers, so a frame_tick on the capture edge still uses the
  // pre-tick values.
  logic [SHEET_AW-1:0] base_addr, side_offset, addr;
  logic [9:0]          dx_eff;
  logic                player_on_d, player_on_q;
  logic [SHEET_AW-1:0] sprite_address_d, sprite_address_q;

  always_comb begin
    unique case (pose_cur)
      IDLE:    base_addr = SHEET_AW'(BASE_IDLE);
      RUN:     base_addr = SHEET_AW'(BASE_RUN);
      DOWN:    base_addr = SHEET_AW'(BASE_DOWN);
      default: base_addr = SHEET_AW'(BASE_JUMP);
    endcase
`ifdef SPRITE_MIRROR_EN
    dx_eff      = facing_cur ? (10'(SPR_W - 1) - dx_q) : dx_q;
    side_offset = '0;
`else
    dx_eff      = dx_q;
    side_offset = facing_cur ? SHEET_AW'(LEFT_OFFSET) : '0;
`endif
    addr = base_addr
         + SHEET_AW'(frame_cur) * SHEET_AW'(SPR_W * SPR_H)
         + SHEET_AW'(dy_q) * SHEET_AW'(SPR_W)
         + SHEET_AW'(dx_eff)
         + side_offset;
    player_on_d      = hit_q;
    sprite_address_d = hit_q ? addr : '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_q            <= 1'b0;
      dx_q             <= '0;
      dy_q             <= '0;
      player_on_q      <= 1'b0;
      sprite_address_q <= '0;
    end else begin
      hit_q            <= hit_d;
      dx_q             <= dx_d;
      dy_q             <= dy_d;
      player_on_q      <= player_on_d;
      sprite_address_q <= sprite_address_d;
    end
  end

  assign playerOn      = player_on_q;
  assign spriteAddress = sprite_address_q;
  assign frameIdx      = frame_cur;
  assign PlayerWidth   = 10'(SPR_W);
  assign PlayerHeight  = 10'(SPR_H);

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Self-checking bench for sprite_anim_engine (default parameters).
// Reference model: animation frame derived from the count of ticks since the
// last pose change; address derived from the sheet layout arithmetic.
module tb_sprite_anim_engine;

  localparam int W = 68;
  localparam int H = 34;
  localparam int NF = 4;
  localparam int DIV = 6;
  localparam int BASES [4] = '{0, 2312, 21680, 23992};

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_tick;
  logic [1:0]  pose;
  logic        facing_left;
  logic [9:0]  DrawX, DrawY, PlayerX, PlayerY;
  logic        playerOn;
  logic [20:0] spriteAddress;
  logic [1:0]  frameIdx;
  logic [9:0]  PlayerWidth, PlayerHeight;

  sprite_anim_engine dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .pose          (pose),
    .facing_left   (facing_left),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .PlayerX       (PlayerX),
    .PlayerY       (PlayerY),
    .playerOn      (playerOn),
    .spriteAddress (spriteAddress),
    .frameIdx      (frameIdx),
    .PlayerWidth   (PlayerWidth),
    .PlayerHeight  (PlayerHeight)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model state: pose, facing and number of same-pose ticks since the last change.
  int m_pose = 0;
  int m_facing = 0;
  int m_n = 0;

  typedef struct {
    logic [31:0] on;
    logic [31:0] addr;
  } pix_exp_t;

  pix_exp_t pq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic int mframe();
    int s;
    s = m_n / DIV;
    if (m_pose == 1) return s % NF;
    if (m_pose == 3) return (s > NF - 1) ? NF - 1 : s;
    return 0;
  endfunction

  function automatic pix_exp_t model_pix(input int px, input int py, input int x, input int y);
    pix_exp_t r;
    int dx, dy, dxe, off;
    r.on = 0;
    r.addr = 0;
    if (x >= px && x < px + W && y >= py && y < py + H) begin
      dx = x - px;
      dy = y - py;
`ifdef SPRITE_MIRROR_EN
      dxe = (m_facing != 0) ? (W - 1 - dx) : dx;
      off = 0;
`else
      dxe = dx;
      off = (m_facing != 0) ? 50620 : 0;
`endif
      r.on = 1;
      r.addr = BASES[m_pose] + mframe() * W * H + dy * W + dxe + off;
    end
    return r;
  endfunction

  task automatic tick(input int p, input int f);
    pose = 2'(p);
    facing_left = f[0];
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (p != m_pose) begin
      m_pose = p;
      m_n = 0;
    end else begin
      m_n++;
    end
    m_facing = f;
  endtask

  task automatic pixel(input string tag, input int x, input int y);
    pix_exp_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    e = model_pix(int'(PlayerX), int'(PlayerY), x, y);
    step();
    step();
    check({tag, "_on"}, {31'd0, playerOn}, e.on);
    check({tag, "_addr"}, {11'd0, spriteAddress}, e.addr);
  endtask

  initial begin
    pix_exp_t e;
    int px, py, x, y, p;

    Reset_n = 1'b0;
    frame_tick = 1'b0;
    pose = 2'd0;
    facing_left = 1'b0;
    DrawX = '0; DrawY = '0; PlayerX = '0; PlayerY = '0;
    step(); step();
    check("reset_on", {31'd0, playerOn}, 0);
    check("reset_addr", {11'd0, spriteAddress}, 0);
    Reset_n = 1'b1;
    step();

    // 1. Reset asserted mid-scan while outputs are non-zero.
    tick(1, 0);
    for (int i = 0; i < 6; i++) tick(1, 0);
    check("t1_frame_before", {30'd0, frameIdx}, mframe());
    PlayerX = 10'd100; PlayerY = 10'd200;
    pixel("t1_pix", 110, 205);
    #2 Reset_n = 1'b0;
    #1;
    check("t1_rst_on", {31'd0, playerOn}, 0);
    check("t1_rst_addr", {11'd0, spriteAddress}, 0);
    check("t1_rst_frame", {30'd0, frameIdx}, 0);
    pose = 2'd0;
    step();
    Reset_n = 1'b1;
    m_pose = 0; m_n = 0; m_facing = 0;
    step();
    check("t1_after_frame", {30'd0, frameIdx}, 0);

    // 2. IDLE hit test and right edge.
    pixel("t2_corner", 100, 200);
    check("t2_corner_const", {11'd0, spriteAddress}, 0);
    pixel("t2_x167", 167, 200);
    check("t2_x167_on", {31'd0, playerOn}, 1);
    pixel("t2_x168", 168, 200);
    check("t2_x168_on", {31'd0, playerOn}, 0);
    pixel("t2_y233", 120, 233);
    pixel("t2_y234", 120, 234);
    pixel("t2_left", 99, 210);

    // 3. RUN animation wraps, then DOWN resets frame.
    tick(1, 0);
    for (int i = 1; i <= 4 * DIV; i++) begin
      tick(1, 0);
      check("t3_run_frame", {30'd0, frameIdx}, mframe());
    end
    check("t3_run_wrapped", {30'd0, frameIdx}, 0);
    pixel("t3_run_pix", 130, 220);
    tick(2, 0);
    check("t3_down_frame", {30'd0, frameIdx}, 0);

    // 4. DOWN facing left at the sprite corner.
    tick(2, 1);
    pixel("t4_corner", 100, 200);
`ifdef SPRITE_MIRROR_EN
    check("t4_const", {11'd0, spriteAddress}, 21747);
`else
    check("t4_const", {11'd0, spriteAddress}, 72300);
`endif
    pixel("t4_inner", 150, 230);

    // 5. Sprite at the right edge of the 10-bit range.
    tick(2, 0);
    PlayerX = 10'd1000; PlayerY = 10'd10;
    pixel("t5_x1023", 1023, 10);
    check("t5_x1023_on", {31'd0, playerOn}, 1);
    for (int i = 0; i <= 5; i++) begin
      pixel("t5_wrap", i, 10);
      check("t5_wrap_on", {31'd0, playerOn}, 0);
    end

    // 6. JUMP saturates; pose change applies only at the tick.
    tick(3, 0);
    for (int i = 0; i < 30; i++) begin
      tick(3, 0);
      check("t6_jump_frame", {30'd0, frameIdx}, mframe());
    end
    check("t6_jump_sat", {30'd0, frameIdx}, 3);
    pose = 2'd1;
    step();
    check("t6_early_frame", {30'd0, frameIdx}, 3);
    pixel("t6_early_pix", 1010, 12);
    // frame_tick on the stage-2 capture edge: output uses pre-tick JUMP frame 3.
    DrawX = 10'd1012; DrawY = 10'd15;
    e = model_pix(1000, 10, 1012, 15);
    step();
    tick(1, 0);
    check("t6_coinc_on", {31'd0, playerOn}, e.on);
    check("t6_coinc_addr", {11'd0, spriteAddress}, e.addr);
    check("t6_run_frame", {30'd0, frameIdx}, 0);
    pixel("t6_new_pose", 1012, 15);

    // Randomised poses, facing and streamed pixels with exact 2-cycle latency.
    for (int it = 0; it < 48; it++) begin
      p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : m_pose;
      tick(p, int'($urandom_range(0, 1)));
      check("rnd_frame", {30'd0, frameIdx}, mframe());
      if (it % 6 == 5) begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
        PlayerX = 10'(px); PlayerY = 10'(py);
        pq.delete();
        for (int k = 0; k < 14; k++) begin
          x = (px + int'($urandom_range(0, W + 9)) - 5) & 1023;
          y = (py + int'($urandom_range(0, H + 9)) - 5) & 1023;
          DrawX = 10'(x); DrawY = 10'(y);
          pq.push_back(model_pix(px, py, x, y));
          step();
          if (pq.size() == 2) begin
            e = pq.pop_front();
            check("rnd_on", {31'd0, playerOn}, e.on);
            check("rnd_addr", {11'd0, spriteAddress}, e.addr);
          end
        end
        step();
        e = pq.pop_front();
        check("rnd_on_last", {31'd0, playerOn}, e.on);
        check("rnd_addr_last", {11'd0, spriteAddress}, e.addr);
      end
    end

    check("width", {22'd0, PlayerWidth}, W);
    check("height", {22'd0, PlayerHeight}, H);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
